// File: rtl/debug_uart_tx.sv
// Debug trace serializer: snapshots {PC, ACC} on a request and sends A5,PC_hi,PC_lo,ACC_hi,ACC_lo as 8N1.
// Latency 1 clk from request edge to start bit; requests while busy are dropped and flagged in sticky overrun.
module debug_uart_tx #(
    parameter int AB           = 11,
    parameter int DB           = 16,
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_uart,
    input  logic [AB-1:0] Addr,
    input  logic [DB-1:0] Acc,
    output logic          tx,
    output logic          busy,
    output logic          frame_done,
    output logic          overrun
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    byte_q, byte_d;
    logic [31:0]   snap_q, snap_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          ovr_q, ovr_d;
    logic          bit_end;
    logic [7:0]    byte_sel;

    assign bit_end = (baud_q == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        snap_d  = snap_q;
        ovr_d   = ovr_q | (wr_uart & busy_q);
        case (state_q)
            S_IDLE: begin
                if (wr_uart) begin
                    state_d = S_START;
                    snap_d  = {16'(Addr), 16'(Acc)};
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    byte_d  = 3'd0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (byte_q == 3'd4) begin
                        byte_d  = 3'd0;
                        state_d = S_IDLE;
                    end else begin
                        byte_d  = byte_q + 3'd1;
                        state_d = S_START;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
        endcase
    end

    // Byte and tx level are derived from next-state values so tx can be a plain register.
    always_comb begin
        case (byte_d)
            3'd1:    byte_sel = snap_d[31:24];
            3'd2:    byte_sel = snap_d[23:16];
            3'd3:    byte_sel = snap_d[15:8];
            3'd4:    byte_sel = snap_d[7:0];
            default: byte_sel = 8'hA5;
        endcase
    end

    always_comb begin
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = byte_sel[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 3'd0;
            snap_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            snap_q  <= snap_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign overrun    = ovr_q;
    assign frame_done = (state_q == S_STOP) && (byte_q == 3'd4) && bit_end;
endmodule

// File: tb/tb_debug_uart_tx.sv
// Randomized bench for debug_uart_tx: cycle-level frame model plus a UART decoder feeding a byte scoreboard.
module tb_debug_uart_tx;
    localparam int AB    = 11;
    localparam int DB    = 16;
    localparam int CPB   = 4;
    localparam int FRAME = 50 * CPB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_uart = 1'b0;
    logic [AB-1:0] Addr = '0;
    logic [DB-1:0] Acc = '0;
    logic          tx, busy, frame_done, overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debug_uart_tx #(.AB(AB), .DB(DB), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .wr_uart(wr_uart), .Addr(Addr), .Acc(Acc),
        .tx(tx), .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycles left in the current frame, the frame's bytes, sticky overrun.
    int         left = 0;
    logic       m_ovr = 1'b0;
    logic [7:0] cur [5];
    logic [7:0] exp_q [$];

    function automatic logic model_tx();
        int t, b, pos;
        if (left == 0) return 1'b1;
        t   = FRAME - left;
        b   = t / CPB;
        pos = b % 10;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return cur[b / 10][pos - 1];
    endfunction

    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            left  = 0;
            m_ovr = 1'b0;
            exp_q.delete();
        end else if (left > 0) begin
            if (wr_uart) m_ovr = 1'b1;
            left = left - 1;
        end else if (wr_uart) begin
            logic [15:0] pc, ac;
            pc = 16'(Addr);
            ac = 16'(Acc);
            cur[0] = 8'hA5;
            cur[1] = pc[15:8];
            cur[2] = pc[7:0];
            cur[3] = ac[15:8];
            cur[4] = ac[7:0];
            for (int i = 0; i < 5; i++) exp_q.push_back(cur[i]);
            left = FRAME;
        end
    end

    // Monitor: per-cycle output checks and mid-bit UART decoding into the byte scoreboard.
    int         mcnt = -1;
    logic [7:0] sh = '0;
    always begin
        @(negedge clk);
        if (!rst_n) begin
            mcnt = -1;
        end else begin
            check("tx", tx, model_tx());
            check("busy", busy, (left > 0));
            check("frame_done", frame_done, (left == 1));
            check("overrun", overrun, m_ovr);
            if (mcnt < 0) begin
                if (tx == 1'b0) mcnt = 0;
            end else begin
                mcnt++;
                if (mcnt >= 6 && mcnt <= 34 && ((mcnt - 6) % 4) == 0) sh[(mcnt - 6) / 4] = tx;
                if (mcnt == 38) begin
                    check("stop_bit", tx, 1'b1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %0h expected none at %0t", sh, $time);
                    end else begin
                        check("rx_byte", sh, exp_q.pop_front());
                    end
                end
                if (mcnt == 39) mcnt = -1;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [AB-1:0] a, input logic [DB-1:0] d);
        Addr    = a;
        Acc     = d;
        wr_uart = 1'b1;
        @(negedge clk);
        #1 wr_uart = 1'b0;
    endtask

    task automatic req(input logic [AB-1:0] a, input logic [DB-1:0] d);
        @(negedge clk);
        #1 pulse(a, d);
    endtask

    initial begin
        idle(3);
        #1 rst_n = 1'b1;
        idle(100);

        req(11'h123, 16'hBEEF);
        idle(205);

        req(11'h456, 16'h1234);
        idle(48);
        #1 pulse(AB'($urandom), DB'($urandom));
        idle(160);

        req(11'h0AB, 16'hCAFE);
        repeat (200) @(negedge clk);
        #1 pulse(11'h2C4, 16'h8001);
        idle(205);

        req(11'h7FF, 16'h0000);
        idle(205);

        for (int i = 0; i < 6; i++) begin
            req(AB'($urandom), DB'($urandom));
            idle($urandom_range(150, 260));
        end

        @(negedge clk);
        #1 Addr = AB'($urandom);
        Acc     = DB'($urandom);
        wr_uart = 1'b1;
        idle(450);
        #1 wr_uart = 1'b0;
        idle(210);

        req(11'h3C3, 16'h5A5A);
        repeat (72) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("reset_tx", tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        idle(5);
        req(11'h155, 16'h0F0F);
        idle(210);

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
